// File: rtl/store_buffer.sv
// In-order store buffer between the CPU load/store stage and a single-port data memory.
// Optional macro SB_FORWARD_EN: loads take data from buffered stores instead of stalling.

module sb_overlap #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] e_addr,
  input  logic             e_byte,
  input  logic [WIDTH-1:0] l_addr,
  input  logic             l_byte,
  output logic             hit
);
  // One extra bit so addr+3 near the top of the space does not wrap.
  logic [WIDTH:0] e_lo, e_hi, l_lo, l_hi;

  always_comb begin
    e_lo = {1'b0, e_addr};
    l_lo = {1'b0, l_addr};
    e_hi = e_lo + {{(WIDTH-1){1'b0}}, ~e_byte, ~e_byte};
    l_hi = l_lo + {{(WIDTH-1){1'b0}}, ~l_byte, ~l_byte};
    hit  = (e_lo <= l_hi) && (l_lo <= e_hi);
  end
endmodule

module store_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [WIDTH-1:0] st_addr,
  input  logic [WIDTH-1:0] st_data,
  input  logic             st_byte,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_addr,
  input  logic             ld_byte,
  output logic [WIDTH-1:0] ld_data,
  output logic             ld_stall,
  output logic             mem_WE,
  output logic             mem_MemType,
  output logic [WIDTH-1:0] mem_A,
  output logic [WIDTH-1:0] mem_WD,
  input  logic [WIDTH-1:0] mem_RD
);
  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [PW-1:0]               head_q, head_d, tail_q, tail_d;
  logic [PW:0]                 cnt_q, cnt_d;
  logic [DEPTH-1:0][WIDTH-1:0] addr_q, addr_d, data_q, data_d;
  logic [DEPTH-1:0]            byte_q, byte_d;
  logic [DEPTH-1:0]            hit, live;
  logic                        push, pop, ld_go, any_hit;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      localparam logic [PW-1:0] SLOT = PW'(g);
      sb_overlap #(.WIDTH(WIDTH)) u_cmp (
        .e_addr (addr_q[g]),
        .e_byte (byte_q[g]),
        .l_addr (ld_addr),
        .l_byte (ld_byte),
        .hit    (hit[g])
      );
      // A slot holds a buffered store when its age from head is below count.
      assign live[g] = {1'b0, SLOT - head_q} < cnt_q;
    end
  endgenerate

  assign any_hit = |(live & hit);

`ifdef SB_FORWARD_EN
  logic [PW-1:0] y_idx, scan;
  logic [1:0]    y_off;
  logic [7:0]    y_byte;

  // Scan oldest to youngest so the last hit is the youngest overlapping store.
  always_comb begin
    y_idx = head_q;
    scan  = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan = head_q + PW'(i);
      if (live[scan] && hit[scan]) y_idx = scan;
    end
    y_off  = ld_addr[1:0] - addr_q[y_idx][1:0];
    y_byte = 8'(data_q[y_idx] >> {y_off, 3'b000});
  end
`endif

  always_comb begin
    ld_stall = 1'b0;
    ld_data  = '0;
    if (rst_n && ld_valid) begin
      if (!any_hit) ld_data = mem_RD;
`ifdef SB_FORWARD_EN
      else if (ld_byte) ld_data = {{(WIDTH-8){1'b0}}, y_byte};
      else if (!byte_q[y_idx] && (addr_q[y_idx] == ld_addr)) ld_data = data_q[y_idx];
`endif
      else ld_stall = 1'b1;
    end
  end

  assign st_ready = rst_n && (cnt_q != FULL);
  assign ld_go    = ld_valid && !ld_stall;
  assign push     = st_valid && st_ready;
  assign pop      = rst_n && (cnt_q != '0) && !ld_go;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    byte_d = byte_q;
    if (push) begin
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
      byte_d[tail_q] = st_byte;
      tail_d         = tail_q + PW'(1);
    end
    if (pop) head_d = head_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // A granted load owns the address port; otherwise it shows the head entry.
  always_comb begin
    mem_WE      = pop;
    mem_A       = '0;
    mem_MemType = 1'b0;
    mem_WD      = '0;
    if (cnt_q != '0) begin
      mem_A       = addr_q[head_q];
      mem_MemType = byte_q[head_q];
      mem_WD      = data_q[head_q];
    end
    if (ld_go) begin
      mem_A       = ld_addr;
      mem_MemType = ld_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    byte_q <= byte_d;
  end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: byte-level memory model plus an architectural view
// (memory overlaid with pending stores) checked against the DUT every cycle.

module tb_store_buffer;
  localparam int DEPTH = 4;

  logic        clk, rst_n;
  logic        st_valid, st_ready, st_byte;
  logic [31:0] st_addr, st_data;
  logic        ld_valid, ld_byte, ld_stall;
  logic [31:0] ld_addr, ld_data;
  logic        mem_WE, mem_MemType;
  logic [31:0] mem_A, mem_WD, mem_RD;

  logic        mem_fill, contract_chk;
  logic [7:0]  mem_arr [256];
  logic [7:0]  mdl_mem [256];
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          bt;
  } st_t;
  st_t q[$];

  store_buffer #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_byte(st_byte),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_byte(ld_byte),
    .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_WE(mem_WE), .mem_MemType(mem_MemType), .mem_A(mem_A),
    .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int midx(input logic [31:0] a);
    return int'({a[17], a[6:0]});
  endfunction

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 37 + 11);
  endfunction

  function automatic bit covers(input st_t e, input logic [31:0] a);
    logic [32:0] lo, x;
    lo = {1'b0, e.addr};
    x  = {1'b0, a};
    if (e.bt) return a == e.addr;
    return (x >= lo) && (x <= lo + 33'd3);
  endfunction

  function automatic bit overlaps(input st_t e, input logic [31:0] la, input bit lb);
    for (int k = 0; k < (lb ? 1 : 4); k++)
      if (covers(e, la + 32'(k))) return 1'b1;
    return 1'b0;
  endfunction

  // What the load must return if every older store had already reached memory.
  function automatic logic [31:0] arch_rd(input logic [31:0] la, input bit lb);
    logic [31:0] r, a;
    logic [7:0]  v;
    r = '0;
    for (int k = 0; k < (lb ? 1 : 4); k++) begin
      a = la + 32'(k);
      v = mdl_mem[midx(a)];
      foreach (q[i]) if (covers(q[i], a)) v = 8'(q[i].data >> (8 * (a - q[i].addr)));
      r[8*k +: 8] = v;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= pat(i);
    end else if (mem_WE) begin
      if (mem_MemType) mem_arr[midx(mem_A)] <= mem_WD[7:0];
      else for (int k = 0; k < 4; k++) mem_arr[midx(mem_A + 32'(k))] <= mem_WD[8*k +: 8];
    end
  end

  always_comb begin
    mem_RD = '0;
    if (mem_MemType) mem_RD[7:0] = mem_arr[midx(mem_A)];
    else for (int k = 0; k < 4; k++) mem_RD[8*k +: 8] = mem_arr[midx(mem_A + 32'(k))];
  end

  initial begin : cmp
    st_t e;
    bit  exp_st, exp_dr, exp_rdy;
    int  yi;
    for (int i = 0; i < 256; i++) mdl_mem[i] = pat(i);
    forever begin
      @(negedge clk);
      exp_rdy = rst_n && (q.size() != DEPTH);
      yi = -1;
      foreach (q[i]) if (overlaps(q[i], ld_addr, ld_byte)) yi = i;
      exp_st = 1'b0;
      if (rst_n && ld_valid && yi >= 0) begin
`ifdef SB_FORWARD_EN
        exp_st = !ld_byte && !(!q[yi].bt && q[yi].addr == ld_addr);
`else
        exp_st = 1'b1;
`endif
      end
      exp_dr = rst_n && (q.size() != 0) && !(ld_valid && !exp_st);

      if (contract_chk && st_valid && ld_valid) begin
        checks++;
        errors++;
        $display("FAIL contract: st_valid and ld_valid both high at %0t", $time);
      end
      chk("st_ready", 32'(st_ready), 32'(exp_rdy));
      chk("ld_stall", 32'(ld_stall), 32'(exp_st));
      chk("mem_WE", 32'(mem_WE), 32'(exp_dr));
      if (exp_dr) chk("mem_WD", mem_WD, q[0].data);
      if (ld_valid && !exp_st) begin
        chk("mem_A_ld", mem_A, ld_addr);
        chk("mem_type_ld", 32'(mem_MemType), 32'(ld_byte));
      end else if (q.size() != 0) begin
        chk("mem_A_head", mem_A, q[0].addr);
        chk("mem_type_head", 32'(mem_MemType), 32'(q[0].bt));
      end else begin
        chk("mem_A_idle", mem_A, 32'd0);
        chk("mem_type_idle", 32'(mem_MemType), 32'd0);
      end
      if (ld_valid && rst_n && !exp_st) chk("ld_data", ld_data, arch_rd(ld_addr, ld_byte));
      if (!ld_valid) chk("ld_data_idle", ld_data, 32'd0);
`ifdef SB_FORWARD_EN
      if (exp_st) chk("ld_data_stall", ld_data, 32'd0);
`endif

      if (!rst_n) q.delete();
      else begin
        if (exp_dr) begin
          e = q.pop_front();
          if (e.bt) mdl_mem[midx(e.addr)] = e.data[7:0];
          else for (int k = 0; k < 4; k++) mdl_mem[midx(e.addr + 32'(k))] = e.data[8*k +: 8];
        end
        if (st_valid && exp_rdy) q.push_back('{addr: st_addr, data: st_data, bt: st_byte});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_nostall(input string nm);
    int n;
    n = 0;
    while (ld_stall && n < 4) begin
      cyc();
      @(negedge clk);
      n++;
    end
    if (ld_stall) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: ld_stall still 1 after %0d cycles", nm, n);
    end
  endtask

  logic [31:0] fa [4];
  logic [31:0] fd [4];
  bit          fb [4];

  initial begin : stim
    int nbad;
    fa = '{32'h10004, 32'h10008, 32'h10040, 32'h1000C};
    fd = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'h000000C5, 32'hD0D1D2D3};
    fb = '{1'b0, 1'b0, 1'b1, 1'b0};
    rst_n = 1'b0; mem_fill = 1'b1; contract_chk = 1'b1;
    st_valid = 1'b0; st_addr = '0; st_data = '0; st_byte = 1'b0;
    ld_valid = 1'b0; ld_addr = '0; ld_byte = 1'b0;

    // reset; the push offered during reset must be dropped
    cyc();
    st_valid = 1'b1; st_addr = 32'h10000; st_data = 32'h12345678;
    cyc();
    rst_n = 1'b1; mem_fill = 1'b0; st_valid = 1'b0;
    @(negedge clk);
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_mem_we", 32'(mem_WE), 32'd0);
    chk("rst_ld_stall", 32'(ld_stall), 32'd0);

    // single word store drains the next cycle
    cyc();
    st_valid = 1'b1; st_addr = 32'h10000; st_data = 32'hDEADBEEF; st_byte = 1'b0;
    cyc();
    st_valid = 1'b0;
    @(negedge clk);
    chk("word_mem_we", 32'(mem_WE), 32'd1);
    chk("word_mem_a", mem_A, 32'h10000);
    chk("word_mem_wd", mem_WD, 32'hDEADBEEF);
    cyc();
    @(negedge clk);
    chk("word_mem_bytes", {mem_arr[midx(32'h10000)], mem_arr[midx(32'h10001)],
                           mem_arr[midx(32'h10002)], mem_arr[midx(32'h10003)]}, 32'hEFBEADDE);

    // fill while a load holds the port, then drain in order
    cyc();
    ld_valid = 1'b1; ld_addr = 32'h20000; ld_byte = 1'b0; contract_chk = 1'b0;
    for (int k = 0; k < 4; k++) begin
      st_valid = 1'b1; st_addr = fa[k]; st_data = fd[k]; st_byte = fb[k];
      cyc();
    end
    st_valid = 1'b0;
    @(negedge clk);
    chk("full_st_ready", 32'(st_ready), 32'd0);
    cyc();
    ld_valid = 1'b0; contract_chk = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("drain_we", 32'(mem_WE), 32'd1);
      chk("drain_addr", mem_A, fa[k]);
      if (k == 0) chk("drain0_st_ready", 32'(st_ready), 32'd0);
      if (k == 1) chk("drain1_st_ready", 32'(st_ready), 32'd1);
      cyc();
    end

    // byte load inside a buffered word store
    st_valid = 1'b1; st_addr = 32'h10010; st_data = 32'h11223344; st_byte = 1'b0;
    cyc();
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h10012; ld_byte = 1'b1;
    @(negedge clk);
`ifdef SB_FORWARD_EN
    chk("fwd_stall", 32'(ld_stall), 32'd0);
    chk("fwd_mem_we", 32'(mem_WE), 32'd0);
`else
    chk("nofwd_stall", 32'(ld_stall), 32'd1);
`endif
    wait_nostall("fwd");
    chk("fwd_data", ld_data, 32'h00000022);
    cyc();
    ld_valid = 1'b0;
    cyc(); cyc();

    // partial overlap always stalls until the store drains
    st_valid = 1'b1; st_addr = 32'h10020; st_data = 32'hAABBCCDD; st_byte = 1'b0;
    cyc();
    st_valid = 1'b0; ld_valid = 1'b1; ld_addr = 32'h10022; ld_byte = 1'b0;
    @(negedge clk);
    chk("part_stall", 32'(ld_stall), 32'd1);
    chk("part_mem_we", 32'(mem_WE), 32'd1);
    chk("part_mem_a", mem_A, 32'h10020);
    cyc();
    @(negedge clk);
    chk("part_stall_clear", 32'(ld_stall), 32'd0);
    chk("part_data_lo", 32'(ld_data[15:0]), 32'h0000AABB);
    chk("part_data_rd", ld_data, mem_RD);
    cyc();
    ld_valid = 1'b0;

    // two byte stores to one address: the younger must win
    cyc();
    ld_valid = 1'b1; ld_addr = 32'h20000; ld_byte = 1'b0; contract_chk = 1'b0;
    st_valid = 1'b1; st_addr = 32'h10030; st_data = 32'h00000001; st_byte = 1'b1;
    cyc();
    st_data = 32'h00000002;
    cyc();
    st_valid = 1'b0; ld_addr = 32'h10030; ld_byte = 1'b1;
    @(negedge clk);
    wait_nostall("young");
    chk("young_data", ld_data, 32'h00000002);

    // reset while stores are still draining
    cyc();
    ld_addr = 32'h20000; ld_byte = 1'b0;
    st_valid = 1'b1; st_addr = 32'h10034; st_data = 32'h55667788; st_byte = 1'b0;
    cyc();
    st_addr = 32'h10038; st_data = 32'h99AABBCC;
    cyc();
    st_valid = 1'b0; ld_valid = 1'b0; contract_chk = 1'b1;
    @(negedge clk);
    chk("rstmid_we_drain", 32'(mem_WE), 32'd1);
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_we_in_rst", 32'(mem_WE), 32'd0);
    chk("rstmid_ready_in_rst", 32'(st_ready), 32'd0);
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_we_after", 32'(mem_WE), 32'd0);
    chk("rstmid_ready_after", 32'(st_ready), 32'd1);
    chk("rstmid_empty_a", mem_A, 32'd0);

    repeat (3) cyc();
    @(negedge clk);
    nbad = 0;
    for (int i = 0; i < 256; i++) if (mem_arr[i] !== mdl_mem[i]) nbad++;
    chk("mem_image", 32'(nbad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
